ps2_key_decoder: RTL

- Upstream stage of game_controller: turns the raw PS/2 keyboard serial stream into the held-key bitmap (iKEY) and the one-shot change strobe that game_controller consumes.
- Runs entirely in the system clock domain.
- Samples ps2_clk/ps2_data through synchronizers, deframes 11-bit frames, and interprets make/break/extended codes.

---
 rtl/ps2_key_decoder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard deframer and held-key bitmap decoder
// Optional macro PS2_BAT_CLEAR_EN: keyboard self-test bytes (0xAA/0xFC) clear the bitmap.
module ps2_key_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TMO_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] oKEY,
    output logic       oChange,
    output logic       oErr
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   bit_in;

    state_t           state, state_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift, shift_n;
    logic             par, par_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_n;
    logic [7:0]       rx_byte, rx_byte_n;
    logic             byte_valid, byte_valid_n;
    logic             err_n;
    logic             timeout;

    logic             e0, f0, enter_held;
    logic             key_hit;
    logic [2:0]       key_idx;
    logic             bat_clear;

    // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in  = data_sync[SYNC_STAGES-1];
    assign timeout = (state != IDLE) && !fall && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par        <= 1'b0;
            tmo_cnt    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            oErr       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            par        <= par_n;
            tmo_cnt    <= tmo_n;
            rx_byte    <= rx_byte_n;
            byte_valid <= byte_valid_n;
            oErr       <= err_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        par_n        = par;
        rx_byte_n    = rx_byte;
        byte_valid_n = 1'b0;
        err_n        = 1'b0;
        tmo_n        = (state == IDLE || fall) ? '0 : tmo_cnt + 1'b1;

        if (timeout) begin
            state_n = IDLE;
            err_n   = 1'b1;
            tmo_n   = '0;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!bit_in) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shift_n   = {bit_in, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = bit_in;
                    state_n = STOP;
                end
                STOP: begin
                    // Odd parity over data plus parity bit, and stop must be high.
                    if (bit_in && (^{shift, par})) begin
                        byte_valid_n = 1'b1;
                        rx_byte_n    = shift;
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        key_hit = 1'b0;
        key_idx = 3'd0;
        if (!e0) begin
            case (rx_byte)
                8'h1D: begin key_hit = 1'b1; key_idx = 3'd0; end
                8'h1B: begin key_hit = 1'b1; key_idx = 3'd1; end
                8'h1C: begin key_hit = 1'b1; key_idx = 3'd2; end
                8'h23: begin key_hit = 1'b1; key_idx = 3'd3; end
                default: ;
            endcase
        end else begin
            case (rx_byte)
                8'h75: begin key_hit = 1'b1; key_idx = 3'd4; end
                8'h72: begin key_hit = 1'b1; key_idx = 3'd5; end
                8'h6B: begin key_hit = 1'b1; key_idx = 3'd6; end
                8'h74: begin key_hit = 1'b1; key_idx = 3'd7; end
                default: ;
            endcase
        end
`ifdef PS2_BAT_CLEAR_EN
        bat_clear = !e0 && !f0 && (rx_byte == 8'hAA || rx_byte == 8'hFC);
`else
        bat_clear = 1'b0;
`endif
    end

    // Code layer: consumes the byte registered at the stop edge one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            oKEY       <= '0;
            oChange    <= 1'b0;
            e0         <= 1'b0;
            f0         <= 1'b0;
            enter_held <= 1'b0;
        end else begin
            oChange <= 1'b0;
            if (oErr) begin
                e0 <= 1'b0;
                f0 <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte == 8'hE0) begin
                    e0 <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    f0 <= 1'b1;
                end else begin
                    e0 <= 1'b0;
                    f0 <= 1'b0;
                    if (bat_clear) begin
                        oKEY       <= '0;
                        enter_held <= 1'b0;
                    end else begin
                        if (key_hit) oKEY[key_idx] <= ~f0;
                        if (!e0 && rx_byte == 8'h5A) begin
                            if (f0) begin
                                enter_held <= 1'b0;
                            end else if (!enter_held) begin
                                enter_held <= 1'b1;
                                oChange    <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end
endmodule
